// File: rtl/alu_issue_stage_if.sv
// ID/EX operand bundle driven into the ALU: op, shift amount, operands and status flags.
// The issue stage drives it through the master modport; the ALU samples it through slave.
interface alu_issue_stage_if;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic        ex_illegal;

  modport master (
    output ex_valid,
    output ex_op,
    output ex_shamt,
    output ex_in1,
    output ex_in2,
    output ex_illegal
  );

  modport slave (
    input ex_valid,
    input ex_op,
    input ex_shamt,
    input ex_in1,
    input ex_in2,
    input ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register: decodes a MIPS instruction into ALU op/shamt/operands,
// with stall, flush, a valid bit, an illegal flag and a saturating issue counter.
module alu_issue_stage #(
  parameter logic [3:0]  ILLEGAL_OP = 4'b1111,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic             stall,
  input  logic             flush,
  alu_issue_stage_if.master ex,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0101;
  localparam logic [3:0] OpSra = 4'b0110;
  localparam logic [3:0] OpNor = 4'b0111;
  localparam logic [3:0] OpSlt = 4'b1000;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_imm_sext;
  logic [31:0] w_imm_zext;
  logic        w_unused;

  assign w_opcode   = id_instr[31:26];
  assign w_funct    = id_instr[5:0];
  assign w_imm      = id_instr[15:0];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_imm_zext = {16'h0000, w_imm};
  // Register specifiers are resolved upstream; only data arrives here.
  assign w_unused   = ^id_instr[25:16];

  logic [3:0]  w_op;
  logic [4:0]  w_shamt;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic        w_illegal;

  always_comb begin
    w_op      = OpAdd;
    w_shamt   = 5'd0;
    w_in1     = id_rs_data;
    w_in2     = id_rt_data;
    w_illegal = 1'b0;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h20, 6'h21: w_op = OpAdd;
          6'h22, 6'h23: w_op = OpSub;
          6'h24:        w_op = OpAnd;
          6'h25:        w_op = OpOr;
          6'h27:        w_op = OpNor;
          6'h2A:        w_op = OpSlt;
          6'h00, 6'h02, 6'h03: begin
            w_op    = (w_funct == 6'h00) ? OpSll : (w_funct == 6'h02) ? OpSrl : OpSra;
            w_in1   = id_rt_data;
            w_shamt = id_instr[10:6];
          end
          default:      w_illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: w_in2 = w_imm_sext;
      6'h0A: begin
        w_op  = OpSlt;
        w_in2 = w_imm_sext;
      end
      6'h0C: begin
        w_op  = OpAnd;
        w_in2 = w_imm_zext;
      end
      6'h0D: begin
        w_op  = OpOr;
        w_in2 = w_imm_zext;
      end
      6'h04, 6'h05: w_op = OpSub;
      default:      w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_op    = ILLEGAL_OP;
      w_shamt = 5'd0;
      w_in1   = '0;
      w_in2   = '0;
    end
  end

  logic             r_valid;
  logic [3:0]       r_op;
  logic [4:0]       r_shamt;
  logic [31:0]      r_in1;
  logic [31:0]      r_in2;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_op      <= 4'b0000;
      r_shamt   <= 5'd0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      // Bubble: counter deliberately untouched.
      r_valid   <= 1'b0;
      r_op      <= 4'b0000;
      r_shamt   <= 5'd0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_illegal <= 1'b0;
    end else if (!stall) begin
      r_valid   <= 1'b1;
      r_op      <= w_op;
      r_shamt   <= w_shamt;
      r_in1     <= w_in1;
      r_in2     <= w_in2;
      r_illegal <= w_illegal;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ex.ex_valid   = r_valid;
  assign ex.ex_op      = r_op;
  assign ex.ex_shamt   = r_shamt;
  assign ex.ex_in1     = r_in1;
  assign ex.ex_in2     = r_in2;
  assign ex.ex_illegal = r_illegal;
  assign issued_cnt    = r_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a decode vector table plus hand-written
// reset, stall/flush, bubble and counter-saturation sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic [15:0] issued_cnt;

  alu_issue_stage_if u_if ();

  alu_issue_stage #(
    .ILLEGAL_OP (4'b1111),
    .CNT_W      (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .stall      (stall),
    .flush      (flush),
    .ex         (u_if),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  op;
    logic [4:0]  shamt;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ill;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic valid, input logic [3:0] op,
                           input logic [4:0] shamt, input logic [31:0] in1,
                           input logic [31:0] in2, input logic ill, input logic [15:0] cnt);
    check({name, ".valid"},   {31'd0, u_if.ex_valid},   {31'd0, valid});
    check({name, ".op"},      {28'd0, u_if.ex_op},      {28'd0, op});
    check({name, ".shamt"},   {27'd0, u_if.ex_shamt},   {27'd0, shamt});
    check({name, ".in1"},     u_if.ex_in1,              in1);
    check({name, ".in2"},     u_if.ex_in2,              in2);
    check({name, ".illegal"}, {31'd0, u_if.ex_illegal}, {31'd0, ill});
    check({name, ".cnt"},     {16'd0, issued_cnt},      {16'd0, cnt});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"sub",   32'h00221822, 32'd7,        32'd9,        4'h1, 5'd0, 32'd7,        32'd9,        1'b0});
    vecs.push_back('{"sra",   32'h000220C3, 32'h00000011, 32'h80000010, 4'h6, 5'd3, 32'h80000010, 32'h80000010, 1'b0});
    vecs.push_back('{"addi",  32'h2041FFFC, 32'd100,      32'd55,       4'h0, 5'd0, 32'd100,      32'hFFFFFFFC, 1'b0});
    vecs.push_back('{"andi",  32'h3041FFFC, 32'hABCD1234, 32'd55,       4'h2, 5'd0, 32'hABCD1234, 32'h0000FFFC, 1'b0});
    vecs.push_back('{"ori",   32'h344100FF, 32'h00001000, 32'd3,        4'h3, 5'd0, 32'h00001000, 32'h000000FF, 1'b0});
    vecs.push_back('{"slti",  32'h28418000, 32'hFFFFFFFF, 32'd3,        4'h8, 5'd0, 32'hFFFFFFFF, 32'hFFFF8000, 1'b0});
    vecs.push_back('{"beq",   32'h10410010, 32'd5,        32'd6,        4'h1, 5'd0, 32'd5,        32'd6,        1'b0});
    vecs.push_back('{"lw",    32'h8C410004, 32'h00002000, 32'd6,        4'h0, 5'd0, 32'h00002000, 32'd4,        1'b0});
    vecs.push_back('{"sw",    32'hAC41FFF0, 32'h00002000, 32'd6,        4'h0, 5'd0, 32'h00002000, 32'hFFFFFFF0, 1'b0});
    vecs.push_back('{"sll",   32'h00021100, 32'd1,        32'h0000000F, 4'h4, 5'd4, 32'h0000000F, 32'h0000000F, 1'b0});
    vecs.push_back('{"srl",   32'h000217C2, 32'd1,        32'hF0000000, 4'h5, 5'd31, 32'hF0000000, 32'hF0000000, 1'b0});
    vecs.push_back('{"nor",   32'h00221827, 32'h0000FFFF, 32'h00FF0000, 4'h7, 5'd0, 32'h0000FFFF, 32'h00FF0000, 1'b0});
    vecs.push_back('{"slt",   32'h0022182A, 32'd3,        32'hFFFFFFFE, 4'h8, 5'd0, 32'd3,        32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"and",   32'h00221824, 32'h12345678, 32'h0F0F0F0F, 4'h2, 5'd0, 32'h12345678, 32'h0F0F0F0F, 1'b0});
    vecs.push_back('{"or",    32'h00221825, 32'd1,        32'd2,        4'h3, 5'd0, 32'd1,        32'd2,        1'b0});
    vecs.push_back('{"addu",  32'h00221821, 32'd10,       32'd20,       4'h0, 5'd0, 32'd10,       32'd20,       1'b0});
    vecs.push_back('{"lui",   32'h3C011234, 32'd10,       32'd20,       4'hF, 5'd0, 32'd0,        32'd0,        1'b1});
    vecs.push_back('{"jr",    32'h00200008, 32'd10,       32'd20,       4'hF, 5'd0, 32'd0,        32'd0,        1'b1});
    vecs.push_back('{"j",     32'h08000010, 32'd10,       32'd20,       4'hF, 5'd0, 32'd0,        32'd0,        1'b1});

    // Reset held with a valid add on the ID side.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_instr = 32'h00221820; id_rs_data = 32'd1; id_rt_data = 32'd2;
    tick();
    check_all("reset0", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, 16'd0);
    tick();
    check_all("reset1", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, 16'd0);
    rst = 1'b0; id_valid = 1'b0;
    tick();
    check_all("post_reset", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, 16'd0);

    // Decode table, one load per vector.
    id_valid = 1'b1;
    foreach (vecs[i]) begin
      id_instr = vecs[i].instr; id_rs_data = vecs[i].rs; id_rt_data = vecs[i].rt;
      tick();
      exp_cnt++;
      check_all(vecs[i].name, 1'b1, vecs[i].op, vecs[i].shamt, vecs[i].in1, vecs[i].in2,
                vecs[i].ill, exp_cnt);
    end

    // Load add, then stall three cycles while the ID side changes.
    id_instr = 32'h00221820; id_rs_data = 32'd11; id_rt_data = 32'd22;
    tick();
    exp_cnt++;
    check_all("add_pre_stall", 1'b1, 4'h0, 5'd0, 32'd11, 32'd22, 1'b0, exp_cnt);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_instr = 32'h3C010000 + k; id_rs_data = 32'd100 + k; id_rt_data = 32'd200 + k;
      tick();
      check_all("stall_hold", 1'b1, 4'h0, 5'd0, 32'd11, 32'd22, 1'b0, exp_cnt);
    end
    flush = 1'b1;
    tick();
    check_all("stall_flush", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, exp_cnt);
    stall = 1'b0; flush = 1'b0;

    // Flush with a valid sub pending: bubble, no count.
    id_instr = 32'h00221822; id_rs_data = 32'd3; id_rt_data = 32'd4;
    flush = 1'b1;
    tick();
    check_all("flush_only", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, exp_cnt);
    flush = 1'b0;

    // Bubble load of an undecodable word: illegal flag stays low.
    id_valid = 1'b0; id_instr = 32'h3C011234;
    tick();
    check_all("bubble_lui", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, exp_cnt);

    // Reset arriving while stalled clears everything.
    id_valid = 1'b1; id_instr = 32'h00221820; id_rs_data = 32'd5; id_rt_data = 32'd6;
    tick();
    exp_cnt++;
    check_all("add_pre_rst", 1'b1, 4'h0, 5'd0, 32'd5, 32'd6, 1'b0, exp_cnt);
    stall = 1'b1; rst = 1'b1;
    tick();
    exp_cnt = '0;
    check_all("rst_in_stall", 1'b0, 4'h0, 5'd0, 32'd0, 32'd0, 1'b0, exp_cnt);
    stall = 1'b0; rst = 1'b0;

    // Saturation: 65535 loads reach all-ones, two more must not wrap.
    for (int k = 0; k < 65535; k++) tick();
    check("sat_reach", {16'd0, issued_cnt}, 32'h0000FFFF);
    tick();
    tick();
    check_all("sat_hold", 1'b1, 4'h0, 5'd0, 32'd5, 32'd6, 1'b0, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU operand/op interface.
- Decodes a fetched MIPS instruction into the 4-bit ALU op, shamt and the two signed 32-bit operands.
- Registers them as the ID/EX pipeline stage that drives the ALU directly.
- Supports stall, flush and a valid bit, and flags unsupported instructions.

Parameters:
- ILLEGAL_OP, 4'b1111, op code driven for undecodable instructions.
- CNT_W, 16, width of the saturating issued-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_instr  input  32  instruction word.
- id_rs_data  input  32  register-file read of rs.
- id_rt_data  input  32  register-file read of rt.
- stall  input  1  hold ID/EX contents (hazard unit).
- flush  input  1  replace ID/EX with bubble (branch taken/mispredict).
- ex_valid  output  1  EX stage holds a real instruction.
- ex_op  output  4  ALU op.
- ex_shamt  output  5  shift amount.
- ex_in1  output  32  ALU operand 1 (signed).
- ex_in2  output  32  ALU operand 2 (signed).
- ex_illegal  output  1  registered instruction was undecodable.
- issued_cnt  output  CNT_W  count of valid instructions loaded into EX.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). All outputs are registered.
- Reset values: ex_valid=0, ex_op=4'b0000, ex_shamt=0, ex_in1=0, ex_in2=0, ex_illegal=0, issued_cnt=0.
- Update priority per rising edge: rst > flush > stall > load.
  - flush: bubble (all outputs at reset values except issued_cnt, which holds).
  - stall: all registers hold.
  - load: register the decode of the ID inputs.
- Latency: one cycle from ID inputs to EX outputs.
- Op encoding: add 0000, sub 0001, and 0010, or 0011, sll 0100, srl 0101, sra 0110, nor 0111, slt 1000 (ALU computes in2>in1 with signed compare).
- R-type (opcode 0), keyed on funct:
  - funct 20/21 → add; 22/23 → sub; 24 → and; 25 → or; 27 → nor; 2A → slt. in1=rs, in2=rt.
  - funct 00 → sll; 02 → srl; 03 → sra. in1=rt (value shifted), in2=rt, shamt=instr[10:6].
  - All non-shift ops: shamt=0.
- I-type, keyed on opcode. in1=rs throughout:
  - 08/09 (addi/addiu), 23 (lw), 2B (sw) → add, in2=sign-ext imm16.
  - 0A (slti) → slt, in2=sign-ext imm16.
  - 0C (andi) → and, in2=zero-ext imm16.
  - 0D (ori) → or, in2=zero-ext imm16.
  - 04/05 (beq/bne) → sub, in2=rt. ALU zero gives equality.
  - shamt=0 for all I-type.
- Illegal decode:
  - Covers any other opcode/funct, including j/jal/lui, which are handled outside this block.
  - Drives op=ILLEGAL_OP, in1=in2=0, shamt=0, ex_illegal=1, and ex_valid as loaded.
- Bubble load: when loading with id_valid=0, outputs take bubble values (as flush). ex_illegal=0 regardless of id_instr.
- issued_cnt: increments on each load with id_valid=1 (illegal included). Saturates at all-ones; no wrap. Unchanged on stall, flush and bubble load.
- Simultaneous stall and flush: flush wins; the bubble is inserted.
- Reset asserted mid-stall: reset wins on that edge.
- Operand values are combinational pass-through of id_rs_data/id_rt_data at the load edge. Forwarding is external.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1, instr=add → all outputs 0, issued_cnt=0 during and one cycle after.
- R-type: load `sub $3,$1,$2` (0x00221822), rs=7, rt=9 → next cycle ex_op=0001, in1=7, in2=9, shamt=0, ex_valid=1, issued_cnt=1.
- Shift and immediates:
  - `sra $4,$2,3` (0x000220C3), rt=0x80000010 → op=0110, in1=0x80000010, shamt=3.
  - `addi` imm=0xFFFC → in2=0xFFFFFFFC.
  - `andi` imm=0xFFFC → in2=0x0000FFFC.
- Stall/flush: load add, then stall=1 for 3 cycles while changing id_instr → outputs hold. Then stall=1 and flush=1 together → bubble, issued_cnt unchanged.
- Illegal: opcode 0x0F (lui) with id_valid=1 → op=1111, ex_illegal=1, in1=in2=0, issued_cnt increments.
- Saturation: preload the counter by issuing 65535 valid loads, then 2 more → issued_cnt=0xFFFF, no wrap.
